// File: rtl/wts_mapper_pkg.sv
// Shared constants and types for the WTS MegaROM bank mapper: register windows,
// bank index decode, SRAM sequencer states and bank register reset values.
package wts_mapper_pkg;

  typedef enum logic [1:0] {BANK0, BANK1, BANK2, BANK3} bank_idx_t;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_HOLD} seq_state_t;

  localparam logic [2:0] ASCII8_WIN_PREFIX = 3'b011;
  localparam logic [1:0] KONAMI_WIN_TAIL   = 2'b10;

  localparam logic [7:0] BANK_RST [4] = '{8'd0, 8'd1, 8'd2, 8'd3};

  // a[14:13]: 10->bank0, 11->bank1, 00->bank2, 01->bank3
  function automatic bank_idx_t bank_of(input logic [1:0] a_14_13);
    return bank_idx_t'({~a_14_13[1], a_14_13[0]});
  endfunction

  // Returns {hit, bank index} for a write/read landing in a bank register window.
  function automatic logic [2:0] reg_window(input logic ascii8, input logic [4:0] a_hi);
    logic [2:0] res;
    res = 3'b000;
    if (ascii8) begin
      if (a_hi[4:2] == ASCII8_WIN_PREFIX) res = {1'b1, a_hi[1:0]};
    end else begin
      if (a_hi[1:0] == KONAMI_WIN_TAIL && (a_hi[4] ^ a_hi[3])) res = {1'b1, a_hi[4], a_hi[2]};
    end
    return res;
  endfunction

endpackage

// File: rtl/wts_sram_sequencer.sv
// Timed SRAM access sequencer with a one-entry request queue and sticky drop flag.
//
// state     | meaning
// ST_IDLE   | no access; serves queued entry first, else a new request
// ST_SETUP  | ncs low, address/data driven
// ST_ACCESS | noe or nwe low for WAIT_CYCLES cycles
// ST_HOLD   | strobes released except ncs; read data valid
module wts_sram_sequencer import wts_mapper_pkg::*; #(
  parameter int AW          = 19,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [7:0]    req_wdata,
  input  logic [7:0]    sram_d_in,
  output logic [AW-1:0] sram_a,
  output logic [7:0]    sram_d_out,
  output logic          sram_ncs,
  output logic          sram_noe,
  output logic          sram_nwe,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic          busy,
  output logic          req_drop
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  seq_state_t    r_state;
  logic          r_ncs, r_noe, r_nwe, r_we;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_data;
  logic [3:0]    r_wait;
  logic          r_q_valid, r_q_we;
  logic [AW-1:0] r_q_addr;
  logic [7:0]    r_q_data;
  logic [7:0]    r_rd_data;
  logic          r_rd_valid, r_drop;

  logic w_busy, w_take_q, w_enq;

  assign w_busy   = (r_state != ST_IDLE);
  assign w_take_q = ~w_busy & r_q_valid;
  // In IDLE a full queue is being drained this cycle, so a new request may refill it.
  assign w_enq    = req & (w_busy ? ~r_q_valid : r_q_valid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_ncs      <= 1'b1;
      r_noe      <= 1'b1;
      r_nwe      <= 1'b1;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_wait     <= '0;
      r_q_valid  <= 1'b0;
      r_q_we     <= 1'b0;
      r_q_addr   <= '0;
      r_q_data   <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_q_valid || req) begin
            r_state <= ST_SETUP;
            r_ncs   <= 1'b0;
            r_we    <= r_q_valid ? r_q_we   : req_we;
            r_addr  <= r_q_valid ? r_q_addr : req_addr;
            r_data  <= r_q_valid ? r_q_data : req_wdata;
          end
        end
        ST_SETUP: begin
          r_state <= ST_ACCESS;
          r_wait  <= WAIT_LOAD;
          if (r_we) r_nwe <= 1'b0;
          else      r_noe <= 1'b0;
        end
        ST_ACCESS: begin
          if (r_wait == 4'd0) begin
            r_state <= ST_HOLD;
            r_noe   <= 1'b1;
            r_nwe   <= 1'b1;
            if (!r_we) begin
              r_rd_data  <= sram_d_in;
              r_rd_valid <= 1'b1;
            end
          end else begin
            r_wait <= r_wait - 4'd1;
          end
        end
        ST_HOLD: begin
          r_state <= ST_IDLE;
          r_ncs   <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_enq) begin
        r_q_valid <= 1'b1;
        r_q_we    <= req_we;
        r_q_addr  <= req_addr;
        r_q_data  <= req_wdata;
      end else if (w_take_q) begin
        r_q_valid <= 1'b0;
      end
      if (req && w_busy && r_q_valid) r_drop <= 1'b1;
    end
  end

  assign sram_a     = r_addr;
  assign sram_d_out = r_data;
  assign sram_ncs   = r_ncs;
  assign sram_noe   = r_noe;
  assign sram_nwe   = r_nwe;
  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;
  assign busy       = w_busy;
  assign req_drop   = r_drop;

endmodule

// File: rtl/wts_bank_mapper.sv
// WTS cartridge MegaROM bank mapper: bank registers, SCC windows, address translation.
// Optional WTS_BANK_READBACK_EN: register-window reads in ROM-mode banks return the bank register.
module wts_bank_mapper import wts_mapper_pkg::*; #(
  parameter int BANK_W      = 6,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic [15:0]       address,
  input  logic [7:0]        wdata,
  input  logic              mapper_ascii8,
  input  logic [3:0]        bank_ram_mode,
  input  logic              wts_mode,
  output logic              scc_sel,
  output logic              scc_bank_en,
  output logic              scc_i_bank_en,
  output logic [BANK_W+12:0] sram_a,
  output logic [7:0]        sram_d_out,
  input  logic [7:0]        sram_d_in,
  output logic              sram_ncs,
  output logic              sram_noe,
  output logic              sram_nwe,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              req_drop
);

  logic [BANK_W-1:0] r_bank [4];
  logic              r_scc_en, r_scc_i_en;

  bank_idx_t          w_bank;
  logic               w_in_range, w_win_hit, w_reg_hit, w_wr, w_rd, w_reg_wr, w_rb_hit;
  logic [1:0]         w_win_idx;
  logic [2:0]         w_win;
  logic               w_seq_req, w_seq_rd_valid;
  logic [7:0]         w_seq_rd_data;
  logic [BANK_W+12:0] w_sram_addr;

  assign w_bank     = bank_of(address[14:13]);
  assign w_in_range = address[15] ^ address[14];
  assign w_win      = reg_window(mapper_ascii8, address[15:11]);
  assign w_win_hit  = w_win[2];
  assign w_win_idx  = w_win[1:0];
  assign w_reg_hit  = w_win_hit & ~bank_ram_mode[w_win_idx];
  assign w_wr       = ce & wr_req;
  assign w_rd       = ce & rd_req & ~wr_req;
  assign w_reg_wr   = w_wr & w_reg_hit;

  assign scc_sel = w_in_range &
                   (((w_bank == BANK2) & r_scc_en & address[12]) |
                    ((w_bank == BANK3) & r_scc_i_en & (address[12] | wts_mode)));

  // Translation uses the pre-edge register value, so a same-edge register write never leaks in.
  assign w_sram_addr = {r_bank[w_bank], address[12:0]};

`ifdef WTS_BANK_READBACK_EN
  assign w_rb_hit = w_reg_hit;
`else
  assign w_rb_hit = 1'b0;
`endif

  assign w_seq_req = w_in_range & ~scc_sel &
                     ((w_wr & ~w_reg_hit & bank_ram_mode[w_bank]) | (w_rd & ~w_rb_hit));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) r_bank[i] <= BANK_W'(BANK_RST[i]);
      r_scc_en   <= 1'b0;
      r_scc_i_en <= 1'b0;
    end else begin
      if (w_reg_wr) r_bank[w_win_idx] <= wdata[BANK_W-1:0];
      if (mapper_ascii8) begin
        r_scc_en   <= 1'b0;
        r_scc_i_en <= 1'b0;
      end else if (w_reg_wr && w_win_idx == BANK2) begin
        r_scc_en   <= (wdata[5:0] == 6'h3F);
      end else if (w_reg_wr && w_win_idx == BANK3) begin
        r_scc_i_en <= wdata[7];
      end
    end
  end

  assign scc_bank_en   = r_scc_en;
  assign scc_i_bank_en = r_scc_i_en;

  wts_sram_sequencer #(.AW(BANK_W + 13), .WAIT_CYCLES(WAIT_CYCLES)) u_seq (
    .clk       (clk),
    .reset     (reset),
    .req       (w_seq_req),
    .req_we    (w_wr),
    .req_addr  (w_sram_addr),
    .req_wdata (wdata),
    .sram_d_in (sram_d_in),
    .sram_a    (sram_a),
    .sram_d_out(sram_d_out),
    .sram_ncs  (sram_ncs),
    .sram_noe  (sram_noe),
    .sram_nwe  (sram_nwe),
    .rd_data   (w_seq_rd_data),
    .rd_valid  (w_seq_rd_valid),
    .busy      (busy),
    .req_drop  (req_drop)
  );

`ifdef WTS_BANK_READBACK_EN
  logic       r_rb_valid, r_rb_sel;
  logic [7:0] r_rb_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rb_valid <= 1'b0;
      r_rb_sel   <= 1'b0;
      r_rb_data  <= '0;
    end else begin
      r_rb_valid <= w_rd & w_rb_hit;
      if (w_rd && w_rb_hit) begin
        r_rb_data <= 8'(r_bank[w_win_idx]);
        r_rb_sel  <= 1'b1;
      end else if (w_seq_rd_valid) begin
        r_rb_sel  <= 1'b0;
      end
    end
  end

  assign rd_valid = w_seq_rd_valid | r_rb_valid;
  assign rd_data  = r_rb_sel ? r_rb_data : w_seq_rd_data;
`else
  assign rd_valid = w_seq_rd_valid;
  assign rd_data  = w_seq_rd_data;
`endif

endmodule

// File: tb/tb_wts_bank_mapper.sv
// Directed bench for wts_bank_mapper: bank decode, SCC windows, SRAM sequencing, queue and reset.
module tb_wts_bank_mapper;

  localparam int BW = 6;
  localparam int WC = 3;
  localparam int AW = BW + 13;

  logic          clk = 1'b0, reset = 1'b1;
  logic          ce = 1'b0, wr_req = 1'b0, rd_req = 1'b0;
  logic          mapper_ascii8 = 1'b0, wts_mode = 1'b0;
  logic [15:0]   address = '0;
  logic [7:0]    wdata = '0;
  logic [3:0]    bank_ram_mode = '0;
  logic          scc_sel, scc_bank_en, scc_i_bank_en;
  logic          sram_ncs, sram_noe, sram_nwe, rd_valid, busy, req_drop;
  logic [AW-1:0] sram_a;
  logic [7:0]    sram_d_out, sram_d_in, rd_data;

  int   n_chk = 0, n_err = 0;
  int   cyc = 0, req_cyc = 0, rv_cyc = 0, ncs_cnt = 0;
  bit   strobe_prev = 1'b0;
  logic [27:0] acc_q [$];
  logic [7:0]  rv_q  [$];

  wts_bank_mapper #(.BANK_W(BW), .WAIT_CYCLES(WC)) dut (
    .clk          (clk),
    .reset        (reset),
    .ce           (ce),
    .wr_req       (wr_req),
    .rd_req       (rd_req),
    .address      (address),
    .wdata        (wdata),
    .mapper_ascii8(mapper_ascii8),
    .bank_ram_mode(bank_ram_mode),
    .wts_mode     (wts_mode),
    .scc_sel      (scc_sel),
    .scc_bank_en  (scc_bank_en),
    .scc_i_bank_en(scc_i_bank_en),
    .sram_a       (sram_a),
    .sram_d_out   (sram_d_out),
    .sram_d_in    (sram_d_in),
    .sram_ncs     (sram_ncs),
    .sram_noe     (sram_noe),
    .sram_nwe     (sram_nwe),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .busy         (busy),
    .req_drop     (req_drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // SRAM returns a simple function of its address
  assign sram_d_in = sram_a[7:0] ^ 8'hA5;

  always @(negedge clk) begin
    if (!sram_ncs) ncs_cnt++;
    if ((!sram_noe || !sram_nwe) && !strobe_prev) acc_q.push_back({~sram_nwe, sram_a, sram_d_out});
    strobe_prev = !sram_noe || !sram_nwe;
    if (rd_valid) begin
      rv_q.push_back(rd_data);
      rv_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] acc_at(input int i);
    return (acc_q.size() > i) ? acc_q[i] : 28'hFFFFFFF;
  endfunction

  function automatic logic [7:0] rv_at(input int i);
    return (rv_q.size() > i) ? rv_q[i] : 8'hXX;
  endfunction

  task automatic clr();
    acc_q.delete();
    rv_q.delete();
    ncs_cnt = 0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic we, input logic [15:0] a, input logic [7:0] d);
    ce = 1'b1; wr_req = we; rd_req = ~we; address = a; wdata = d;
    req_cyc = cyc;
    @(posedge clk); #1;
    ce = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [15:0] a, input logic [18:0] exp_a);
    clr();
    bus(1'b0, a, 8'h00);
    settle(12);
    check({tag, "_addr"}, 32'(acc_at(0) >> 8), 32'({1'b0, exp_a}));
    check({tag, "_data"}, 32'(rv_at(0)), 32'(exp_a[7:0] ^ 8'hA5));
    check({tag, "_lat"}, 32'(rv_cyc - req_cyc), 32'(WC + 2));
  endtask

  initial begin
    settle(2);
    check("rst_strobes", 32'({sram_ncs, sram_noe, sram_nwe}), 32'h7);
    check("rst_sram_a", 32'(sram_a), 32'h0);
    check("rst_rd_data", 32'(rd_data), 32'h0);
    check("rst_flags", 32'({rd_valid, busy, req_drop, scc_bank_en, scc_i_bank_en}), 32'h0);
    reset = 1'b0;
    settle(1);

    read_chk("rd4000", 16'h4000, 19'h00000);
    read_chk("rd6000", 16'h6000, 19'h02000);
    read_chk("rd8000", 16'h8000, 19'h04000);
    read_chk("rdA000", 16'hA000, 19'h06000);

    // Konami SCC window
    clr();
    bus(1'b1, 16'h9000, 8'h3F);
    settle(8);
    check("kon_regwr_nosram", 32'(acc_q.size()), 32'd0);
    check("scc_en", 32'(scc_bank_en), 32'd1);
    address = 16'h9800;
    #1 check("scc_sel_9800", 32'(scc_sel), 32'd1);
    clr();
    bus(1'b0, 16'h9800, 8'h00);
    settle(10);
    check("scc_no_ncs", 32'(ncs_cnt), 32'd0);
    check("scc_no_rv", 32'(rv_q.size()), 32'd0);
    address = 16'h8800;
    #1 check("scc_sel_8800", 32'(scc_sel), 32'd0);
    read_chk("rd8800", 16'h8800, 19'h7E800);

    // SCC-I window, widened by wts_mode
    bus(1'b1, 16'hB000, 8'h80);
    settle(1);
    check("scci_en", 32'(scc_i_bank_en), 32'd1);
    address = 16'hA000; wts_mode = 1'b0;
    #1 check("scci_sel_narrow", 32'(scc_sel), 32'd0);
    wts_mode = 1'b1;
    #1 check("scci_sel_wide", 32'(scc_sel), 32'd1);
    wts_mode = 1'b0;
    bus(1'b1, 16'hB000, 8'h03);
    settle(1);
    check("scci_off", 32'(scc_i_bank_en), 32'd0);

    // ASCII8 layout
    mapper_ascii8 = 1'b1;
    settle(1);
    check("a8_scc_forced", 32'(scc_bank_en), 32'd0);
    clr();
    bus(1'b1, 16'h7000, 8'h05);
    settle(8);
    check("a8_regwr_nosram", 32'(acc_q.size()), 32'd0);
    read_chk("rd8123", 16'h8123, 19'h0A123);

    // Back-to-back reads: one served, one queued, one dropped
    clr();
    ce = 1'b1; rd_req = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      address = 16'h4000 + 16'(i);
      @(posedge clk); #1;
    end
    ce = 1'b0; rd_req = 1'b0;
    settle(25);
    check("b2b_count", 32'(acc_q.size()), 32'd2);
    check("b2b_first", 32'(acc_at(0) >> 8), 32'h00001);
    check("b2b_second", 32'(acc_at(1) >> 8), 32'h00002);
    check("b2b_data0", 32'(rv_at(0)), 32'hA4);
    check("b2b_data1", 32'(rv_at(1)), 32'hA7);
    check("b2b_drop", 32'(req_drop), 32'd1);

    // RAM-mode bank1: window write goes to SRAM, register untouched
    mapper_ascii8 = 1'b0;
    bank_ram_mode = 4'b0010;
    settle(1);
    clr();
    bus(1'b1, 16'h7000, 8'h55);
    settle(12);
    check("ram_wr", 32'(acc_at(0)), 32'({1'b1, 19'h03000, 8'h55}));
    check("ram_wr_no_rv", 32'(rv_q.size()), 32'd0);
    bank_ram_mode = 4'b0000;
    read_chk("b1_keep", 16'h6000, 19'h02000);

    // Reset asserted mid-ACCESS with a queued entry
    bus(1'b0, 16'h4000, 8'h00);
    bus(1'b0, 16'h4004, 8'h00);
    check("pre_rst_noe", 32'(sram_noe), 32'd0);
    #2 reset = 1'b1;
    #1 check("mid_rst_strobes", 32'({sram_ncs, sram_noe, sram_nwe}), 32'h7);
    check("mid_rst_busy", 32'(busy), 32'd0);
    settle(2);
    reset = 1'b0;
    clr();
    settle(15);
    check("post_rst_q_empty", 32'(ncs_cnt), 32'd0);
    check("post_rst_no_rv", 32'(rv_q.size()), 32'd0);
    check("post_rst_drop", 32'(req_drop), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
